// File: rtl/vlsu_pkg.sv
// Shared store-path types and helpers: the per-burst control entry and the
// ceil-divide used to size bursts in bus beats.
package vlsu_pkg;

  localparam int unsigned MaxOffsetWidth = 8;
  localparam int unsigned MaxLenWidth    = 32;
  localparam int unsigned PosWidth       = MaxLenWidth + 1;
  localparam int unsigned SumWidth       = MaxLenWidth + 2;

  // Widths are fixed at their maximum so the type is usable at any bus width.
  typedef struct packed {
    logic [MaxOffsetWidth-1:0] offset;
    logic [MaxLenWidth-1:0]    nbytes;
  } store_txn_t;

  function automatic logic [PosWidth-1:0] ceil_beats(input logic [PosWidth-1:0] nbytes,
                                                     input int unsigned bsize);
    logic [SumWidth-1:0] sum;
    sum = {1'b0, nbytes} + (SumWidth'(1) << bsize) - SumWidth'(1);
    return PosWidth'(sum >> bsize);
  endfunction

endpackage

// File: rtl/store_w_align.sv
// Byte realigner: shifts the current stream word up by the start offset and
// fills the low bytes from the residue carried over from the previous word.
module store_w_align
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64
) (
  input  logic [AxiDataWidth-1:0]              word_i,
  input  logic [AxiDataWidth-1:0]              residue_i,
  input  logic [$clog2(AxiDataWidth/8)-1:0]    offset_i,
  output logic [AxiDataWidth-1:0]              beat_o,
  output logic [AxiDataWidth-1:0]              residue_o
);

  localparam int unsigned busBytes = AxiDataWidth / 8;
  localparam int unsigned busBSize = $clog2(busBytes);

  genvar gi;
  for (gi = 0; gi < busBytes; gi++) begin : g_byte
    logic [busBSize-1:0] src;
    // Source index wraps modulo B: below the offset it addresses the word's top bytes.
    assign src = busBSize'(gi) - offset_i;
    assign beat_o[gi*8 +: 8]    = (busBSize'(gi) >= offset_i) ? word_i[src*8 +: 8]
                                                               : residue_i[gi*8 +: 8];
    assign residue_o[gi*8 +: 8] = (busBSize'(gi) < offset_i) ? word_i[src*8 +: 8] : 8'h00;
  end

endmodule

// File: rtl/store_w_packer.sv
// Packs a contiguous store byte stream into AXI W beats aligned to the
// burst's start offset, with byte strobes, wlast and a done pulse.
module store_w_packer
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned LenWidth     = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 txn_valid_i,
  output logic                                 txn_ready_o,
  input  logic [$clog2(AxiDataWidth/8)-1:0]    txn_offset_i,
  input  logic [LenWidth-1:0]                  txn_nbytes_i,
  input  logic                                 seq_valid_i,
  output logic                                 seq_ready_o,
  input  logic [AxiDataWidth-1:0]              seq_data_i,
  output logic                                 w_valid_o,
  input  logic                                 w_ready_i,
  output logic [AxiDataWidth-1:0]              w_data_o,
  output logic [AxiDataWidth/8-1:0]            w_strb_o,
  output logic                                 w_last_o,
  output logic                                 txn_done_o
);

  localparam int unsigned busBytes = AxiDataWidth / 8;
  localparam int unsigned busBSize = $clog2(busBytes);
  localparam int unsigned CntWidth = LenWidth - busBSize + 1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]              state_reg, state_next;
  store_txn_t              txn_reg;
  logic [CntWidth-1:0]     k_reg, in_words_reg, out_beats_reg;
  logic [CntWidth-1:0]     in_words_next, out_beats_next;
  logic [AxiDataWidth-1:0] residue_reg, residue_next, align_word, beat_data;
  logic                    txn_ready_reg;
  logic                    txn_fire, w_fire, beat_valid, is_last;
  logic [busBSize-1:0]     off;
  logic [PosWidth-1:0]     start_pos, end_pos;
  logic [busBytes-1:0]     strb;

  assign off       = txn_reg.offset[busBSize-1:0];
  assign start_pos = PosWidth'(txn_reg.offset);
  assign end_pos   = PosWidth'(txn_reg.nbytes) + start_pos;

  assign in_words_next  = CntWidth'(ceil_beats(PosWidth'(txn_nbytes_i), busBSize));
  assign out_beats_next = CntWidth'(ceil_beats(PosWidth'(txn_nbytes_i) + PosWidth'(txn_offset_i),
                                               busBSize));

  always_comb begin
    beat_valid  = 1'b0;
    seq_ready_o = 1'b0;
    case (state_reg)
      STREAM: begin
        beat_valid  = seq_valid_i;
        seq_ready_o = w_ready_i;
      end
      FLUSH:   beat_valid = 1'b1;
      default: ;
    endcase
  end

  // The flush beat has no input word; only the carried residue contributes.
  assign align_word = (state_reg == STREAM) ? seq_data_i : '0;

  store_w_align #(
    .AxiDataWidth(AxiDataWidth)
  ) u_align (
    .word_i   (align_word),
    .residue_i(residue_reg),
    .offset_i (off),
    .beat_o   (beat_data),
    .residue_o(residue_next)
  );

  genvar gi;
  for (gi = 0; gi < busBytes; gi++) begin : g_strb
    logic [PosWidth-1:0] pos;
    assign pos     = PosWidth'({k_reg, busBSize'(gi)});
    assign strb[gi] = (pos >= start_pos) && (pos < end_pos);
  end

  assign txn_fire    = txn_valid_i & txn_ready_reg;
  assign is_last     = (k_reg == out_beats_reg - CntOne);
  assign w_fire      = beat_valid & w_ready_i;
  assign w_valid_o   = beat_valid;
  assign w_data_o    = beat_valid ? beat_data : '0;
  assign w_strb_o    = beat_valid ? strb : '0;
  assign w_last_o    = beat_valid & is_last;
  assign txn_done_o  = w_fire & is_last;
  assign txn_ready_o = txn_ready_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (txn_fire) state_next = STREAM;
      STREAM: begin
        if (w_fire) begin
          if (is_last)                          state_next = IDLE;
          else if (k_reg + CntOne == in_words_reg) state_next = FLUSH;
        end
      end
      FLUSH:   if (w_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      txn_reg       <= '0;
      k_reg         <= '0;
      in_words_reg  <= '0;
      out_beats_reg <= '0;
      residue_reg   <= '0;
      txn_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // Registered so no ready input reaches txn_ready_o combinationally.
      txn_ready_reg <= (state_next == IDLE);
      if (txn_fire) begin
        txn_reg.offset <= MaxOffsetWidth'(txn_offset_i);
        txn_reg.nbytes <= MaxLenWidth'(txn_nbytes_i);
        in_words_reg   <= in_words_next;
        out_beats_reg  <= out_beats_next;
        k_reg          <= '0;
        residue_reg    <= '0;
      end else if (w_fire) begin
        k_reg       <= k_reg + CntOne;
        residue_reg <= residue_next;
      end
    end
  end

  a_nbytes_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
    txn_fire |-> (txn_nbytes_i != '0));

endmodule

// File: tb/tb_store_w_packer.sv
// Directed bench for store_w_packer: expected W beats are built from a byte
// image of each burst, queued at transaction start and popped per beat.
module tb_store_w_packer;

  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        txn_valid, txn_ready;
  logic [2:0]  txn_offset;
  logic [15:0] txn_nbytes;
  logic        seq_valid, seq_ready;
  logic [63:0] seq_data;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last, txn_done;

  always #5 clk = ~clk;

  store_w_packer #(.AxiDataWidth(64), .LenWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .txn_valid_i(txn_valid), .txn_ready_o(txn_ready),
    .txn_offset_i(txn_offset), .txn_nbytes_i(txn_nbytes),
    .seq_valid_i(seq_valid), .seq_ready_o(seq_ready), .seq_data_i(seq_data),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
    .w_strb_o(w_strb), .w_last_o(w_last), .txn_done_o(txn_done)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] in_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_in_words, cur_out_beats;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Builds the expected beats from in_q, then performs the control handshake
  // in the idle cycle while offering junk on the stream side.
  task automatic start_txn(input int off, input int n);
    logic [7:0]  img[0:63];
    logic        en[0:63];
    logic [63:0] w;
    beat_t       e;
    cur_in_words  = (n + B - 1) / B;
    cur_out_beats = (off + n + B - 1) / B;
    for (int i = 0; i < 64; i++) begin
      img[i] = 8'h00;
      en[i]  = 1'b0;
    end
    for (int j = 0; j < n; j++) begin
      w = in_q[j / B];
      img[off + j] = w[(j % B) * 8 +: 8];
      en[off + j]  = 1'b1;
    end
    for (int b = 0; b < cur_out_beats; b++) begin
      for (int i = 0; i < B; i++) begin
        e.data[i*8 +: 8] = img[b*B + i];
        e.strb[i]        = en[b*B + i];
      end
      e.last = (b == cur_out_beats - 1);
      exp_q.push_back(e);
    end
    txn_valid  = 1'b1;
    txn_offset = 3'(off);
    txn_nbytes = 16'(n);
    seq_valid  = 1'b1;
    seq_data   = {$urandom, $urandom};
    w_ready    = 1'b1;
    @(negedge clk);
    chk1("idle_txn_ready", txn_ready, 1'b1);
    chk1("idle_w_valid", w_valid, 1'b0);
    chk1("idle_seq_ready", seq_ready, 1'b0);
    chk1("idle_done", txn_done, 1'b0);
    @(posedge clk);
    #1;
    txn_valid = 1'b0;
  endtask

  task automatic do_beat(input int b, input int stall);
    beat_t e;
    logic  in_phase;
    in_phase  = (b < cur_in_words);
    seq_valid = in_phase;
    seq_data  = in_phase ? in_q[b] : {$urandom, $urandom};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=beat%0d expected=none", b);
      return;
    end
    e = exp_q[0];
    for (int s = 0; s < stall; s++) begin
      w_ready = 1'b0;
      @(negedge clk);
      chk1("stall_w_valid", w_valid, 1'b1);
      chk1("stall_seq_ready", seq_ready, 1'b0);
      chk64("stall_data", w_data & strb_mask(e.strb), e.data);
      chk64("stall_strb", 64'(w_strb), 64'(e.strb));
      chk1("stall_last", w_last, e.last);
      chk1("stall_done", txn_done, 1'b0);
      @(posedge clk);
      #1;
    end
    w_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    chk1("w_valid", w_valid, 1'b1);
    chk1("seq_ready", seq_ready, in_phase);
    chk64("w_data", w_data & strb_mask(e.strb), e.data);
    chk64("w_strb", 64'(w_strb), 64'(e.strb));
    chk1("w_last", w_last, e.last);
    chk1("txn_done", txn_done, e.last);
    chk1("busy_txn_ready", txn_ready, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int off, input int n, input int stall_b, input int stall_n);
    start_txn(off, n);
    for (int b = 0; b < cur_out_beats; b++) do_beat(b, (b == stall_b) ? stall_n : 0);
    chk1("scoreboard_drained", exp_q.size() == 0, 1'b1);
    $display("txn off=%0d n=%0d beats=%0d checks=%0d errors=%0d",
             off, n, cur_out_beats, checks, errors);
  endtask

  initial begin
    rst_n      = 1'b1;
    txn_valid  = 1'b0;
    txn_offset = '0;
    txn_nbytes = '0;
    seq_valid  = 1'b0;
    seq_data   = '0;
    w_ready    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_w_valid", w_valid, 1'b0);
    chk1("rst_txn_ready", txn_ready, 1'b0);
    chk1("rst_seq_ready", seq_ready, 1'b0);
    chk1("rst_w_last", w_last, 1'b0);
    chk1("rst_done", txn_done, 1'b0);
    chk64("rst_w_strb", 64'(w_strb), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned two-word burst.
    in_q = {64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
    run_txn(0, 16, -1, 0);
    // Offset 3, one word spilling into a flush beat.
    in_q = {64'h0706050403020100};
    run_txn(3, 8, -1, 0);
    // Offset 2, short single beat.
    in_q = {64'h1122334455667788};
    run_txn(2, 5, -1, 0);
    // Offset 5, three words, stalled on beat 1.
    in_q = {64'hA7A6A5A4A3A2A1A0, 64'hB7B6B5B4B3B2B1B0, 64'hC7C6C5C4C3C2C1C0};
    run_txn(5, 20, 1, 3);

    // Reset in the middle of a burst.
    in_q = {64'hD7D6D5D4D3D2D1D0, 64'hE7E6E5E4E3E2E1E0};
    start_txn(3, 16);
    do_beat(0, 0);
    seq_valid = 1'b1;
    seq_data  = in_q[1];
    w_ready   = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    chk1("midrst_w_valid", w_valid, 1'b0);
    chk1("midrst_seq_ready", seq_ready, 1'b0);
    chk1("midrst_txn_ready", txn_ready, 1'b0);
    chk1("midrst_w_last", w_last, 1'b0);
    chk1("midrst_done", txn_done, 1'b0);
    chk64("midrst_w_strb", 64'(w_strb), 64'h0);
    chk64("midrst_w_data", w_data, 64'h0);
    exp_q.delete();
    $display("txn off=3 n=16 abandoned by reset checks=%0d errors=%0d", checks, errors);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    seq_valid = 1'b0;
    @(posedge clk);
    #1;
    in_q = {64'h8877665544332211};
    run_txn(0, 8, -1, 0);

    // Back-to-back bursts; the second must carry no residue from the first.
    in_q = {64'h0F1E2D3C4B5A6978};
    run_txn(1, 8, -1, 0);
    in_q = {64'h123456789ABCDEF0};
    run_txn(0, 8, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_w_packer.md
Name: store_w_packer

Overview:
- Store-direction counterpart of the load path. The load path turns AXI R beats into lane data; this block does the reverse step at the AXI end.
- Input: a sequential byte stream, bus-width words in element order, already de-shuffled from the lanes.
- Output: AXI W beats. Each beat is realigned to the transaction's start byte offset, with byte strobes and wlast.
- Sits between the store de-shuffle stage and the AXI W channel. Driven by one transaction-control entry per AXI burst.

Parameters:
- AxiDataWidth, 64, AXI data bus width in bits (power of 2, >= 32).
- LenWidth, 16, width of the transaction byte count.
- busBytes (local), AxiDataWidth/8, bytes per beat (B).
- busBSize (local), $clog2(busBytes), byte-offset width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- txn_valid_i  in  1  transaction control valid.
- txn_ready_o  out  1  transaction control ready.
- txn_offset_i  in  busBSize  start byte offset within the first beat (addr[busBSize-1:0]).
- txn_nbytes_i  in  LenWidth  bytes to write; must be >= 1.
- seq_valid_i  in  1  input word valid.
- seq_ready_o  out  1  input word ready.
- seq_data_i  in  AxiDataWidth  B contiguous stream bytes; byte 0 is the earliest.
- w_valid_o  out  1  AXI W valid.
- w_ready_i  in  1  AXI W ready.
- w_data_o  out  AxiDataWidth  AXI W data.
- w_strb_o  out  busBytes  AXI W strobe.
- w_last_o  out  1  AXI W last.
- txn_done_o  out  1  one-cycle pulse on the handshake of the final beat.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset state: IDLE. Residue, counters and offset cleared. txn_ready_o=1 after release. All other outputs 0.
- States: IDLE, STREAM, FLUSH.
- IDLE:
  - txn_ready_o=1; seq_ready_o=0; w_valid_o=0.
  - On txn handshake, latch off=txn_offset_i and n=txn_nbytes_i.
  - Compute in_words=ceil(n/B) and out_beats=ceil((off+n)/B); out_beats is in_words or in_words+1.
  - Clear beat index k=0 and the residue. Go to STREAM.
- STREAM:
  - w_valid_o = seq_valid_i; seq_ready_o = w_ready_i (combinational pass-through, zero latency).
  - Beat data: byte i for i>=off is seq_data_i byte i-off. Byte i for i<off is residue byte i, where residue holds the previous input word's bytes B-off..B-1.
  - On a W handshake: residue <= current word's top off bytes; k++.
  - If this handshake is the final beat: wlast, done, go to IDLE.
  - Else if in_words words are now consumed and out_beats>in_words: go to FLUSH.
- FLUSH:
  - w_valid_o=1; seq_ready_o=0.
  - Data bytes 0..off-1 come from the residue; remaining bytes are 0.
  - w_last_o=1. On handshake: txn_done_o pulses, go to IDLE.
- Strobe: w_strb_o[i]=1 iff off <= k*B+i < off+n. First-beat bytes below off and last-word bytes beyond n are 0.
- w_last_o = (k==out_beats-1) whenever w_valid_o=1.
- Backpressure rules:
  - While w_valid_o=1 and w_ready_i=0: w_data_o, w_strb_o and w_last_o hold stable.
  - No input is consumed and no state changes.
- Combinational paths:
  - w_ready_i -> seq_ready_o exists.
  - seq_valid_i -> w_valid_o exists.
  - No combinational path from any ready input to txn_ready_o.
- off==0: FLUSH is never entered; beats equal words.
- txn_ready_o is asserted only in IDLE, so there is a 1-cycle bubble between transactions.
- n==0 is illegal; it is flagged by an assertion and behaviour is undefined.
- Arithmetic: beat and word counters are LenWidth-busBSize+1 bits wide. off+n is computed at LenWidth+1 bits with no overflow.
- Reset mid-operation: all outputs drop to 0 immediately on rst_ni assertion. The partial burst is abandoned with no residue carried over.

Decomposition:
- Shared package vlsu_pkg:
  - typedef store_txn_t with fields offset and nbytes.
  - helper function for ceil-div beat count.
- Natural sub-module store_w_align: combinational byte realigner taking current word, residue and offset, producing the beat data.
- Strobe generation and the FSM stay in store_w_packer.

Test Plan:
All cases use AxiDataWidth=64, B=8.
- off=0, n=16, words 0x0706..00 and 0x0F0E..08, w_ready=1:
  - 2 beats, data equals input, strb 0xFF and 0xFF.
  - last on beat 2; done pulses once; FLUSH never entered.
- off=3, n=8, one word with bytes 00..07:
  - beat0 bytes3..7 = 00..04, strb 0xF8, last=0.
  - FLUSH beat bytes0..2 = 05..07, strb 0x07, last=1.
- off=2, n=5, one word:
  - single beat bytes2..6 = in0..4, strb 0x7C, last=1; no FLUSH.
- off=5, n=20, w_ready low for 3 cycles on beat1:
  - w_data/strb held stable and seq_ready=0 during the stall.
  - 4 beats with strb 0xE0, 0xFF, 0xFF, 0x01.
- Reset asserted in STREAM after beat0:
  - w_valid_o=0 in the same cycle; after release, txn_ready_o=1.
  - a new off=0, n=8 transaction yields strb 0xFF with no stale residue.
- Two back-to-back transactions (off=1, n=8, then off=0, n=8):
  - exactly one idle cycle between them.
  - second burst strobe 0xFF, residue not leaked.
